counter_100_checker: RTL and testbench



---
 rtl/counter_100_checker.sv | 148 ++++++++++++++
 tb/tb_counter_100_checker.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/counter_100_checker.sv
// Sink-side checker for a 0..CNT_MAX wrap-around count stream.
// Locks after SYNC_LEN consecutive correct samples, then flags mismatches and counts wraps.
module counter_100_checker #(
  parameter int unsigned CNT_MAX  = 99,
  parameter int unsigned CW       = 7,
  parameter int unsigned SYNC_LEN = 4,
  parameter int unsigned ERR_W    = 8,
  parameter int unsigned WRAP_W   = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_en,
  input  logic [CW-1:0]     i_cnt,
  input  logic              i_clr,
  output logic [1:0]        o_state,
  output logic              o_locked,
  output logic              o_err,
  output logic [ERR_W-1:0]  o_err_cnt,
  output logic [WRAP_W-1:0] o_wrap_cnt
);

  localparam int unsigned MW = $clog2(SYNC_LEN + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [CW-1:0]       expected, expected_nxt;
  logic [MW-1:0]       match_cnt, match_cnt_nxt;
  logic                locked_nxt;
  logic                err_nxt;
  logic [ERR_W-1:0]    err_cnt_nxt;
  logic [WRAP_W-1:0]   wrap_cnt_nxt;
  logic                err_hit;
  logic                illegal;
  logic                match;
  logic [CW-1:0]       cnt_succ;

  // Sample classification and successor of the observed value
  always_comb begin
    illegal  = (i_cnt > CW'(CNT_MAX));
    match    = (i_cnt == expected);
    cnt_succ = (i_cnt == CW'(CNT_MAX)) ? '0 : i_cnt + CW'(1);
  end

  // Next-state and output computation
  always_comb begin
    state_nxt     = state;
    expected_nxt  = expected;
    match_cnt_nxt = match_cnt;
    err_nxt       = o_err;
    err_cnt_nxt   = o_err_cnt;
    wrap_cnt_nxt  = o_wrap_cnt;
    err_hit       = 1'b0;

    if (i_en) begin
      unique case (state)
        IDLE: begin
          if (!illegal) begin
            state_nxt     = SYNC;
            expected_nxt  = cnt_succ;
            match_cnt_nxt = MW'(1);
          end
        end
        SYNC: begin
          if (illegal) begin
            state_nxt     = IDLE;
            match_cnt_nxt = '0;
          end else if (match) begin
            expected_nxt  = cnt_succ;
            match_cnt_nxt = match_cnt + MW'(1);
            if (match_cnt + MW'(1) == MW'(SYNC_LEN)) begin
              state_nxt = LOCKED;
            end
          end else begin
            expected_nxt  = cnt_succ;
            match_cnt_nxt = MW'(1);
          end
        end
        LOCKED: begin
          if (illegal) begin
            err_hit       = 1'b1;
            state_nxt     = IDLE;
            match_cnt_nxt = '0;
          end else if (match) begin
            expected_nxt = cnt_succ;
            // expected == 0 only follows a CNT_MAX sample, so a matching 0 is a wrap
            if (i_cnt == '0) begin
              wrap_cnt_nxt = o_wrap_cnt + WRAP_W'(1);
            end
          end else begin
            err_hit       = 1'b1;
            state_nxt     = SYNC;
            expected_nxt  = cnt_succ;
            match_cnt_nxt = MW'(1);
          end
        end
        default: begin
          state_nxt     = IDLE;
          match_cnt_nxt = '0;
        end
      endcase
    end

    if (err_hit) begin
      err_nxt = 1'b1;
      if (o_err_cnt != '1) begin
        err_cnt_nxt = o_err_cnt + ERR_W'(1);
      end
    end

    // Clear overrides any same-cycle error or wrap update
    if (i_clr) begin
      err_nxt      = 1'b0;
      err_cnt_nxt  = '0;
      wrap_cnt_nxt = '0;
    end

    locked_nxt = (state_nxt == LOCKED);
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      expected   <= '0;
      match_cnt  <= '0;
      o_locked   <= 1'b0;
      o_err      <= 1'b0;
      o_err_cnt  <= '0;
      o_wrap_cnt <= '0;
    end else begin
      state      <= state_nxt;
      expected   <= expected_nxt;
      match_cnt  <= match_cnt_nxt;
      o_locked   <= locked_nxt;
      o_err      <= err_nxt;
      o_err_cnt  <= err_cnt_nxt;
      o_wrap_cnt <= wrap_cnt_nxt;
    end
  end

  assign o_state = state;

endmodule

// File: tb/tb_counter_100_checker.sv
// Directed bench for counter_100_checker: lock, wraps, error injection, clear, saturation, async reset.
module tb_counter_100_checker;

  logic        clk;
  logic        reset_n;
  logic        en;
  logic [6:0]  cnt;
  logic        clr;
  logic [1:0]  state;
  logic        locked;
  logic        err;
  logic [7:0]  err_cnt;
  logic [15:0] wrap_cnt;
  logic [1:0]  s_state;
  logic        s_locked;
  logic        s_err;
  logic [1:0]  s_err_cnt;
  logic [15:0] s_wrap_cnt;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  counter_100_checker dut (
    .clk(clk), .reset_n(reset_n), .i_en(en), .i_cnt(cnt), .i_clr(clr),
    .o_state(state), .o_locked(locked), .o_err(err),
    .o_err_cnt(err_cnt), .o_wrap_cnt(wrap_cnt)
  );

  counter_100_checker #(.ERR_W(2)) dut_sat (
    .clk(clk), .reset_n(reset_n), .i_en(en), .i_cnt(cnt), .i_clr(clr),
    .o_state(s_state), .o_locked(s_locked), .o_err(s_err),
    .o_err_cnt(s_err_cnt), .o_wrap_cnt(s_wrap_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply one sample at the falling edge; return just after the next rising edge
  task automatic step(input logic e, input int unsigned v, input logic c);
    @(negedge clk);
    en  = e;
    cnt = 7'(v);
    clr = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    en = 1'b0;
    cnt = '0;
    clr = 1'b0;
    #12;
    check("rst_state", 32'(state), 0);
    check("rst_locked", 32'(locked), 0);
    check("rst_err", 32'(err), 0);
    check("rst_err_cnt", 32'(err_cnt), 0);
    check("rst_wrap", 32'(wrap_cnt), 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Lock on 0,1,2,3
    step(1, 0, 0);
    check("sync_after_0", 32'(state), 1);
    step(1, 1, 0);
    step(1, 2, 0);
    check("not_locked_3rd", 32'(locked), 0);
    step(1, 3, 0);
    check("locked_4th", 32'(locked), 1);
    check("state_locked", 32'(state), 2);

    // Clean stream through two wraps
    for (int v = 4; v <= 99; v++) step(1, v, 0);
    check("wrap_before", 32'(wrap_cnt), 0);
    step(1, 0, 0);
    check("wrap_first", 32'(wrap_cnt), 1);
    for (int v = 1; v <= 99; v++) step(1, v, 0);
    step(1, 0, 0);
    check("wrap_second", 32'(wrap_cnt), 2);
    check("clean_err", 32'(err), 0);
    check("clean_err_cnt", 32'(err_cnt), 0);

    // Legal mismatch: 50 where 41 is expected
    for (int v = 1; v <= 40; v++) step(1, v, 0);
    step(1, 50, 0);
    check("mm_err", 32'(err), 1);
    check("mm_err_cnt", 32'(err_cnt), 1);
    check("mm_state", 32'(state), 1);
    step(1, 51, 0);
    step(1, 52, 0);
    check("mm_resync", 32'(state), 1);
    step(1, 53, 0);
    check("mm_relock", 32'(locked), 1);
    check("mm_err_sticky", 32'(err), 1);

    // Illegal sample while locked, then illegal stream in IDLE
    step(1, 120, 0);
    check("ill_err_cnt", 32'(err_cnt), 2);
    check("ill_state", 32'(state), 0);
    for (int k = 0; k < 3; k++) step(1, 127, 0);
    check("idle_hold", 32'(state), 0);
    check("idle_err_cnt", 32'(err_cnt), 2);

    // Enable toggling with stream held (and garbage while disabled)
    step(1, 10, 0);
    step(0, 10, 0);
    step(1, 11, 0);
    step(0, 99, 0);
    step(1, 12, 0);
    step(0, 12, 0);
    check("en_sync", 32'(state), 1);
    check("en_no_err", 32'(err_cnt), 2);
    step(1, 13, 0);
    check("en_locked", 32'(locked), 1);

    // Clear together with an injected error (expected 14)
    step(1, 30, 1);
    check("clr_err", 32'(err), 0);
    check("clr_err_cnt", 32'(err_cnt), 0);
    check("clr_wrap", 32'(wrap_cnt), 0);
    check("clr_state", 32'(state), 1);
    check("clr_sat", 32'(s_err_cnt), 0);

    // Five errors: 8-bit counter reaches 5, 2-bit counter saturates at 3
    for (int k = 0; k < 5; k++) begin
      for (int v = 0; v <= 3; v++) step(1, v, 0);
      check("sat_locked", 32'(locked), 1);
      step(1, 120, 0);
      if (k == 3) check("sat_at_4", 32'(s_err_cnt), 3);
    end
    check("five_err_cnt", 32'(err_cnt), 5);
    check("sat_err_cnt", 32'(s_err_cnt), 3);
    check("sat_err", 32'(s_err), 1);

    // Async reset between edges
    for (int v = 0; v <= 3; v++) step(1, v, 0);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_state", 32'(state), 0);
    check("arst_locked", 32'(locked), 0);
    check("arst_err", 32'(err), 0);
    check("arst_err_cnt", 32'(err_cnt), 0);
    check("arst_wrap", 32'(wrap_cnt), 0);
    check("arst_sat_cnt", 32'(s_err_cnt), 0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int v = 0; v <= 3; v++) step(1, v, 0);
    check("relock", 32'(locked), 1);
    check("relock_err", 32'(err_cnt), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
